// File: rtl/note_arbiter_pkg.sv
// Shared definitions for the note arbiter: note codes, owner/state encoding
// and the helper that folds out-of-range note codes onto "none".
package note_arbiter_pkg;

    typedef logic [3:0] note_t;

    localparam note_t NOTE_C5   = 4'd0;
    localparam note_t NOTE_B    = 4'd1;
    localparam note_t NOTE_A    = 4'd2;
    localparam note_t NOTE_G    = 4'd3;
    localparam note_t NOTE_F    = 4'd4;
    localparam note_t NOTE_E    = 4'd5;
    localparam note_t NOTE_D    = 4'd6;
    localparam note_t NOTE_C4   = 4'd7;
    localparam note_t NOTE_NONE = 4'd8;

    // The encoding doubles as the GRANT output value.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_AUTO   = 2'b01,
        ST_MANUAL = 2'b10,
        ST_TAIL   = 2'b11
    } state_e;

    // Codes 9..15 are not notes; treat them as silence.
    function automatic note_t clean_note(input note_t n);
        return (n > NOTE_NONE) ? NOTE_NONE : n;
    endfunction

endpackage

// File: rtl/note_arbiter_if.sv
// Bundle of the arbiter's request inputs and tone/autoplay outputs.
//   slave  : the arbiter (consumes key/autoplay/ack, drives tone/grant)
//   master : the surroundings (keyboard, sequencer, tone generator)
// Tone handshake: tone_valid rises with a new tone_note; tone_note is held
// stable while tone_valid is high; a cycle with tone_ack and tone_valid both
// high completes the transfer; tone_ack while tone_valid is low is ignored.
interface note_arbiter_if;
    import note_arbiter_pkg::*;

    logic        mode;
    logic        beat_tick;
    logic        key_req;
    note_t       key_note;
    note_t       auto_note;
    logic        tone_ack;
    note_t       tone_note;
    logic        tone_valid;
    logic        auto_run;
    logic        auto_restart;
    logic [1:0]  grant;

    modport slave (
        input  mode, beat_tick, key_req, key_note, auto_note, tone_ack,
        output tone_note, tone_valid, auto_run, auto_restart, grant
    );

    modport master (
        output mode, beat_tick, key_req, key_note, auto_note, tone_ack,
        input  tone_note, tone_valid, auto_run, auto_restart, grant
    );

endinterface

// File: rtl/note_arbiter_tone_handshake.sv
// Offer register toward the shared tone generator.
//   req_note   : currently requested note (already cleaned)
//   tone_ack   : generator has loaded tone_note
//   tone_note  : offered note, stable while tone_valid is high
//   tone_valid : offered note is new and not yet acknowledged
// A new note is offered only while idle and only if it differs from the last
// acknowledged note; requests that come and go during a transfer are dropped.
module tone_handshake
    import note_arbiter_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  note_t req_note,
    input  logic  tone_ack,
    output note_t tone_note,
    output logic  tone_valid
);

    logic  valid_q, valid_d;
    note_t note_q, note_d;
    note_t last_ack_q, last_ack_d;

    always_comb begin
        valid_d    = valid_q;
        note_d     = note_q;
        last_ack_d = last_ack_q;
        if (valid_q) begin
            // Completion takes the whole cycle: the next offer can only be
            // evaluated once valid is low, giving at least one idle cycle.
            if (tone_ack) begin
                valid_d    = 1'b0;
                last_ack_d = note_q;
            end
        end else if (req_note != last_ack_q) begin
            note_d  = req_note;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q    <= 1'b0;
            note_q     <= NOTE_NONE;
            last_ack_q <= NOTE_NONE;
        end else begin
            valid_q    <= valid_d;
            note_q     <= note_d;
            last_ack_q <= last_ack_d;
        end
    end

    assign tone_note  = note_q;
    assign tone_valid = valid_q;

endmodule

// File: rtl/note_arbiter.sv
// Arbitrates the single tone generator between the autoplay sequencer and the
// piano keys. A released key keeps ownership for HOLD_BEATS beat ticks (TAIL)
// before autoplay resumes where it paused.
//   clk, rst    : clock, asynchronous active-high reset
//   bus         : request inputs and tone/grant outputs (slave side)
//   state_dbg   : current owner state, for observation
module note_arbiter
    import note_arbiter_pkg::*;
#(
    parameter int HOLD_BEATS = 2
) (
    input  logic            clk,
    input  logic            rst,
    note_arbiter_if.slave   bus,
    output state_e          state_dbg
);

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    note_t      latch_q, latch_d;
    logic       restart_q, restart_d;
    note_t      req_note;

    localparam logic [3:0] LAST_TICK = 4'(HOLD_BEATS - 1);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        restart_d = 1'b0;
        // Track the most recent held key so TAIL keeps sounding it.
        latch_d   = bus.key_req ? clean_note(bus.key_note) : latch_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.key_req) begin
                    state_d = ST_MANUAL;
                end else if (!bus.mode) begin
                    state_d   = ST_AUTO;
                    restart_d = 1'b1;
                end
            end
            ST_AUTO: begin
                if (bus.key_req) begin
                    state_d = ST_MANUAL;
                end else if (bus.mode) begin
                    state_d = ST_IDLE;
                end
            end
            ST_MANUAL: begin
                if (!bus.key_req) begin
                    state_d = ST_TAIL;
                    cnt_d   = 4'd0;
                end
            end
            ST_TAIL: begin
                if (bus.key_req) begin
                    state_d = ST_MANUAL;
                end else if (bus.beat_tick) begin
                    if (cnt_q == LAST_TICK) begin
                        // Resuming from TAIL never restarts the song.
                        state_d = bus.mode ? ST_IDLE : ST_AUTO;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        req_note = NOTE_NONE;
        case (state_q)
            ST_IDLE:   req_note = NOTE_NONE;
            ST_AUTO:   req_note = clean_note(bus.auto_note);
            ST_MANUAL: req_note = clean_note(bus.key_note);
            ST_TAIL:   req_note = latch_q;
            default:   req_note = NOTE_NONE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 4'd0;
            latch_q   <= NOTE_NONE;
            restart_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            latch_q   <= latch_d;
            restart_q <= restart_d;
        end
    end

    tone_handshake u_hs (
        .clk        (clk),
        .rst        (rst),
        .req_note   (req_note),
        .tone_ack   (bus.tone_ack),
        .tone_note  (bus.tone_note),
        .tone_valid (bus.tone_valid)
    );

    assign bus.grant        = state_q;
    assign bus.auto_run     = (state_q == ST_AUTO);
    assign bus.auto_restart = restart_q;
    assign state_dbg        = state_q;

endmodule
